// File: rtl/data_bus_xbar.sv
// Registered 11x11 byte crossbar: each destination register loads the source named by its 4-bit selector.
// Optional XBAR_SEL_ERR_EN adds a registered sel_err flag for reserved selector codes 11-14.
module data_bus_xbar #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] sp_in,
  input  logic [WIDTH-1:0] add_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] stat_in,
  input  logic [WIDTH-1:0] mem_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] fetch_in,
  input  logic [WIDTH-1:0] decode_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [3:0]       pc_selector,
  input  logic [3:0]       sp_selector,
  input  logic [3:0]       add_selector,
  input  logic [3:0]       x_selector,
  input  logic [3:0]       y_selector,
  input  logic [3:0]       stat_selector,
  input  logic [3:0]       mem_selector,
  input  logic [3:0]       fetch_selector,
  input  logic [3:0]       decode_selector,
  input  logic [3:0]       alu0_selector,
  input  logic [3:0]       alu1_selector,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] sp_out,
  output logic [WIDTH-1:0] add_out,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] stat_out,
  output logic [WIDTH-1:0] mem_out,
  output logic [WIDTH-1:0] fetch_out,
  output logic [WIDTH-1:0] decode_out,
  output logic [WIDTH-1:0] alu0_out,
  output logic [WIDTH-1:0] alu1_out
`ifdef XBAR_SEL_ERR_EN
  ,
  output logic             sel_err
`endif
);

  localparam int unsigned SEL_W     = 4;
  localparam int unsigned NUM_SRC   = 11;
  localparam int unsigned NUM_DST   = 11;
  localparam int unsigned NUM_CODES = 16;

  localparam logic [SEL_W-1:0] SEL_HOLD = 4'd15;

  // Source table indexed directly by selector code; codes 11-15 read zero (15 is overridden by hold).
  logic [WIDTH-1:0] src_c [NUM_CODES];
  logic [SEL_W-1:0] sel_c [NUM_DST];
  logic [WIDTH-1:0] dst_d [NUM_DST];
  logic [WIDTH-1:0] dst_q [NUM_DST];

  always_comb begin
    for (int i = 0; i < int'(NUM_CODES); i++) begin
      src_c[i] = '0;
    end
    src_c[0]  = pc_in;
    src_c[1]  = sp_in;
    src_c[2]  = add_in;
    src_c[3]  = x_in;
    src_c[4]  = y_in;
    src_c[5]  = stat_in;
    src_c[6]  = mem_in;
    src_c[7]  = imm_in;
    src_c[8]  = fetch_in;
    src_c[9]  = decode_in;
    src_c[10] = alu_in;
  end

  always_comb begin
    sel_c[0]  = pc_selector;
    sel_c[1]  = sp_selector;
    sel_c[2]  = add_selector;
    sel_c[3]  = x_selector;
    sel_c[4]  = y_selector;
    sel_c[5]  = stat_selector;
    sel_c[6]  = mem_selector;
    sel_c[7]  = fetch_selector;
    sel_c[8]  = decode_selector;
    sel_c[9]  = alu0_selector;
    sel_c[10] = alu1_selector;
  end

  always_comb begin
    for (int d = 0; d < int'(NUM_DST); d++) begin
      dst_d[d] = dst_q[d];
      if (sel_c[d] != SEL_HOLD) begin
        dst_d[d] = src_c[sel_c[d]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < int'(NUM_DST); d++) begin
        dst_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < int'(NUM_DST); d++) begin
        dst_q[d] <= dst_d[d];
      end
    end
  end

  assign pc_out     = dst_q[0];
  assign sp_out     = dst_q[1];
  assign add_out    = dst_q[2];
  assign x_out      = dst_q[3];
  assign y_out      = dst_q[4];
  assign stat_out   = dst_q[5];
  assign mem_out    = dst_q[6];
  assign fetch_out  = dst_q[7];
  assign decode_out = dst_q[8];
  assign alu0_out   = dst_q[9];
  assign alu1_out   = dst_q[10];

`ifdef XBAR_SEL_ERR_EN
  logic sel_err_d;
  logic sel_err_q;

  // Flags any destination whose selector holds a reserved code this cycle.
  always_comb begin
    sel_err_d = 1'b0;
    for (int d = 0; d < int'(NUM_DST); d++) begin
      if ((sel_c[d] >= SEL_W'(NUM_SRC)) && (sel_c[d] != SEL_HOLD)) begin
        sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_data_bus_xbar.sv
// Scoreboard bench for data_bus_xbar: driver pushes expected register contents, monitor pops and compares each edge.
module tb_data_bus_xbar;

  localparam int unsigned W = 8;
  localparam int unsigned N = 11;

  typedef struct packed {
    logic                err;
    logic [N-1:0][W-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] src_v [N];
  logic [3:0]   sel_v [N];
  logic [W-1:0] out_v [N];
`ifdef XBAR_SEL_ERR_EN
  logic         sel_err;
`endif

  string dst_name [N] = '{"pc_out", "sp_out", "add_out", "x_out", "y_out", "stat_out",
                          "mem_out", "fetch_out", "decode_out", "alu0_out", "alu1_out"};

  // Source index order matches selector codes 0..10; destination order matches out_v.
  localparam int PC = 0, SP = 1, ADD = 2, X = 3, Y = 4, STAT = 5, MEM = 6, IMM = 7,
                 FETCH = 8, DECODE = 9, ALU = 10;
  localparam int D_MEM = 6, D_ALU0 = 9, D_ALU1 = 10;

  data_bus_xbar #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (src_v[0]),
    .sp_in          (src_v[1]),
    .add_in         (src_v[2]),
    .x_in           (src_v[3]),
    .y_in           (src_v[4]),
    .stat_in        (src_v[5]),
    .mem_in         (src_v[6]),
    .imm_in         (src_v[7]),
    .fetch_in       (src_v[8]),
    .decode_in      (src_v[9]),
    .alu_in         (src_v[10]),
    .pc_selector    (sel_v[0]),
    .sp_selector    (sel_v[1]),
    .add_selector   (sel_v[2]),
    .x_selector     (sel_v[3]),
    .y_selector     (sel_v[4]),
    .stat_selector  (sel_v[5]),
    .mem_selector   (sel_v[6]),
    .fetch_selector (sel_v[7]),
    .decode_selector(sel_v[8]),
    .alu0_selector  (sel_v[9]),
    .alu1_selector  (sel_v[10]),
    .pc_out         (out_v[0]),
    .sp_out         (out_v[1]),
    .add_out        (out_v[2]),
    .x_out          (out_v[3]),
    .y_out          (out_v[4]),
    .stat_out       (out_v[5]),
    .mem_out        (out_v[6]),
    .fetch_out      (out_v[7]),
    .decode_out     (out_v[8]),
    .alu0_out       (out_v[9]),
    .alu1_out       (out_v[10])
`ifdef XBAR_SEL_ERR_EN
    ,
    .sel_err        (sel_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];
  logic [N-1:0][W-1:0] model;
  exp_t mon_e;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < int'(N); d++) check({tag, ":", dst_name[d]}, out_v[d], '0);
`ifdef XBAR_SEL_ERR_EN
    check({tag, ":sel_err"}, W'(sel_err), '0);
`endif
  endtask

  // Reference: each destination gets the named source, zero for 11-14, its previous value for 15.
  task automatic step();
    exp_t e;
    @(negedge clk);
    e.err = 1'b0;
    for (int d = 0; d < int'(N); d++) begin
      int s;
      s = int'(sel_v[d]);
      if (s <= 10) e.v[d] = src_v[s];
      else if (s == 15) e.v[d] = model[d];
      else begin
        e.v[d] = '0;
        e.err  = 1'b1;
      end
    end
    model = e.v;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic randomize_inputs(input int max_sel);
    for (int i = 0; i < int'(N); i++) begin
      src_v[i] = W'($urandom);
      sel_v[i] = 4'($urandom_range(max_sel, 0));
    end
  endtask

  // Monitor: one expected record is retired on every edge outside reset.
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int d = 0; d < int'(N); d++) check(dst_name[d], out_v[d], mon_e.v[d]);
`ifdef XBAR_SEL_ERR_EN
      check("sel_err", W'(sel_err), W'(mon_e.err));
`endif
    end
  end

  initial begin
    model = '0;
    reset = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      src_v[i] = 8'hA5;
      sel_v[i] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset_hold");

    @(negedge clk);
    #1;
    reset = 1'b0;
    step();
    check("first_load_pc", out_v[0], 8'hA5);

    // Every destination pulls the same source: broadcast of each code.
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        src_v[i] = W'($urandom);
        sel_v[i] = 4'(k);
      end
      src_v[k] = 8'h10 + W'(k);
      step();
    end

    randomize_inputs(15);
    sel_v[D_MEM]  = 4'(X);   src_v[X]   = 8'h3C;
    sel_v[D_ALU0] = 4'(MEM); src_v[MEM] = 8'h7E;
    sel_v[D_ALU1] = 4'(IMM); src_v[IMM] = 8'h01;
    step();
    check("mixed_mem", out_v[D_MEM], 8'h3C);
    check("mixed_alu0", out_v[D_ALU0], 8'h7E);
    check("mixed_alu1", out_v[D_ALU1], 8'h01);

    sel_v[X] = 4'(X); src_v[X] = 8'h55;
    step();
    sel_v[X] = 4'd15; src_v[X] = 8'hFF;
    step();
    check("hold_x", out_v[X], 8'h55);
    sel_v[X] = 4'd12;
    step();
    check("reserved_x", out_v[X], 8'h00);

    sel_v[PC] = 4'(PC); src_v[PC] = 8'h11;
    step();
    src_v[PC] = 8'h22;
    #1;
    check("latency_before_edge", out_v[PC], 8'h11);
    step();
    check("latency_after_edge", out_v[PC], 8'h22);

    src_v[Y] = 'x;
    sel_v[0] = 4'(Y);
    step();

    randomize_inputs(10);
    for (int i = 0; i < int'(N); i++) src_v[i] = src_v[i] | 8'h01;
    step();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    #1;
    reset = 1'b0;
    model = '0;
    sel_v[STAT] = 4'd15;
    step();
    check("post_reset_hold_zero", out_v[STAT], 8'h00);

    repeat (300) begin
      randomize_inputs(15);
      step();
    end

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_bus_xbar.md
Name: data_bus_xbar

Overview:
- Registered 11-source × 11-destination byte crossbar for the CPU datapath.
- Each destination has its own 4-bit selector that picks one source: architectural registers, memory, immediate, fetcher, decoder or ALU.
- Selectors are driven by the instruction decoder; outputs feed register inputs, memory write data, fetcher, decoder and both ALU operands.
- Sits between the register file / memory and the fetch/decode/ALU units.

Parameters:
- WIDTH, 8, data width of every source and destination port.

Ports:
- clk  in  1  datapath clock; all outputs update on the rising edge.
- reset  in  1  asynchronous active-high reset.
- pc_in, sp_in, add_in, x_in, y_in, stat_in  in  WIDTH each  register file outputs.
- mem_in  in  WIDTH  memory read data.
- imm_in  in  WIDTH  immediate operand from fetcher.
- fetch_in  in  WIDTH  fetcher register output.
- decode_in  in  WIDTH  decoder data output.
- alu_in  in  WIDTH  ALU result.
- pc_selector, sp_selector, add_selector, x_selector, y_selector, stat_selector, mem_selector, fetch_selector, decode_selector, alu0_selector, alu1_selector  in  4 each  per-destination source select.
- pc_out, sp_out, add_out, x_out, y_out, stat_out  out  WIDTH each  register write data.
- mem_out  out  WIDTH  memory write data.
- fetch_out  out  WIDTH  fetcher data input.
- decode_out  out  WIDTH  decoder data input.
- alu0_out, alu1_out  out  WIDTH each  ALU operands A and B.

Behaviour:
- Selector encoding, identical for every destination:
  - 0 PC, 1 SP, 2 ADD, 3 X, 4 Y, 5 STAT, 6 MEM, 7 IMM, 8 FETCH, 9 DECODE, 10 ALU.
  - 11–14 load 8'h00.
  - 15 HOLD: destination keeps its current value.
- Each output is a WIDTH-bit register, independent of all others.
- On every rising clk edge with reset low, each output loads the source named by its selector.
- Latency: exactly 1 clk from source/selector change to output.
- Outputs never change between edges.
- Reset:
  - While reset is high, all 11 outputs are 8'h00 immediately (asynchronous), independent of clk.
  - The first edge after reset deasserts performs a normal load.
- Reset asserted mid-operation clears all outputs at once; no partial-update state is retained.
- Broadcast: any number of destinations may select the same source in the same cycle; all receive the identical value.
- Loopback: a destination may select its own register source (e.g. pc_selector=0 gives pc_out <= pc_in); this is legal, with no special casing.
- X/Z on a selected source propagates unchanged to the output.
- Unselected sources have no effect.
- No handshake, no backpressure, no internal state beyond the 11 output registers.
- Purely a data router: write enables belong to consumers, not to this block.

Optional Feature:
- Macro XBAR_SEL_ERR_EN.
- When defined:
  - Adds output sel_err (1 bit, registered, reset 0).
  - On each edge, sel_err loads 1 if any of the 11 selectors holds a reserved code 11–14, else 0.
  - Data behaviour is unchanged.
- When undefined: no sel_err port and no related logic.

Test Plan:
- Reset: drive all inputs 8'hA5, selectors 0, assert reset between edges → all outputs 8'h00 immediately; deassert, one edge → pc_out=8'hA5.
- Per-source routing: set source k to 8'h10+k and all selectors to k, for k=0..10 → after one edge every output = 8'h10+k.
- Mixed routing: mem_selector=3 (x_in=8'h3C), alu0_selector=6 (mem_in=8'h7E), alu1_selector=7 (imm_in=8'h01) → mem_out=3C, alu0_out=7E, alu1_out=01 on the same edge.
- Hold and reserved: load x_out=8'h55, then x_selector=15 with x_in=8'hFF → x_out stays 55; x_selector=12 → x_out=00 (sel_err=1 if XBAR_SEL_ERR_EN).
- Latency: change pc_in 8'h11→8'h22 between edges with pc_selector=0 → pc_out shows 22 only after the next rising edge.
- Mid-run reset: routing active with nonzero outputs, pulse reset for less than one cycle → outputs 00 during the pulse, resume normal loads on the next edge.
